// File: rtl/mem_stage.sv
// Memory pipeline stage: drives a single-beat data bus for loads/stores, stalls upstream until the
// bus answers, and registers the writeback. Optional misaligned-access traps: MEM_MISALIGN_EXC_EN.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [5:0]  mem_flags_i,
  input  logic        mem_ex_sel_i,
  input  logic        exc_addr_if_i,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_sel_o,
  output logic        dmem_we_o,
  output logic        dmem_cyc_o,
  input  logic [31:0] dmem_data_i,
  input  logic        dmem_ack_i,
  input  logic        dmem_err_i,
  output logic [31:0] wb_result_o,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_we_o,
  output logic        mem_stall_o,
  output logic        exc_load_o,
  output logic        exc_store_o,
  output logic        exc_bus_o,
  output logic        exc_addr_if_o
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic [3:0]  sel_q, sel_d;
  logic        bus_we_q, bus_we_d, ld_sel_q, ld_sel_d, uns_q, uns_d, rf_we_q, rf_we_d;
  logic [1:0]  size_q, size_d, lane_q, lane_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic        wb_we_q, wb_we_d;
  logic        exc_load_q, exc_load_d, exc_store_q, exc_store_d;
  logic        exc_bus_q, exc_bus_d, exc_addr_if_q, exc_addr_if_d;

  logic        is_load, is_store, mis_exc, start, done;
  logic [1:0]  size, a_lo, lane;
  logic [3:0]  sel_req;
  logic [31:0] wdata_req;
  logic        unused_flag;

  assign is_load     = mem_flags_i[0];
  assign is_store    = mem_flags_i[1];
  assign size        = mem_flags_i[3:2];
  assign a_lo        = result_i[1:0];
  assign unused_flag = mem_flags_i[5];

`ifdef MEM_MISALIGN_EXC_EN
  assign mis_exc = (is_load || is_store) &&
                   ((size == 2'b01 && a_lo[0]) || (size[1] && a_lo != 2'b00));
`else
  assign mis_exc = 1'b0;
`endif

  // An op already flagged by fetch never reaches the bus.
  assign start = (is_load || is_store) && !mis_exc && !exc_addr_if_i;
  assign done  = (state_q == ACCESS) && (dmem_ack_i || dmem_err_i);

  // Misaligned halves/words fall back to the containing aligned lane.
  always_comb begin
    lane      = 2'b00;
    sel_req   = 4'b1111;
    wdata_req = store_data_i;
    case (size)
      2'b00: begin
        lane      = a_lo;
        sel_req   = 4'b0001 << a_lo;
        wdata_req = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        lane      = {a_lo[1], 1'b0};
        sel_req   = 4'b0011 << {a_lo[1], 1'b0};
        wdata_req = {2{store_data_i[15:0]}};
      end
      default: begin
        lane      = 2'b00;
        sel_req   = 4'b1111;
        wdata_req = store_data_i;
      end
    endcase
  end

  function automatic logic [31:0] load_extract(input logic [31:0] data, input logic [1:0] ln,
                                               input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = data >> {ln, 3'b000};
    case (sz)
      2'b00:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return data;
    endcase
  endfunction

  // Bus outputs: live decode in the request cycle, frozen copy while waiting.
  always_comb begin
    dmem_cyc_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_sel_o   = 4'b0000;
    dmem_addr_o  = 32'h0;
    dmem_wdata_o = 32'h0;
    mem_stall_o  = 1'b0;
    if (rst) begin
      if (state_q == ACCESS) begin
        dmem_cyc_o   = 1'b1;
        dmem_we_o    = bus_we_q;
        dmem_sel_o   = sel_q;
        dmem_addr_o  = addr_q;
        dmem_wdata_o = wdata_q;
        mem_stall_o  = !(dmem_ack_i || dmem_err_i);
      end else if (start) begin
        dmem_cyc_o   = 1'b1;
        dmem_we_o    = is_store;
        dmem_sel_o   = sel_req;
        dmem_addr_o  = {result_i[31:2], 2'b00};
        dmem_wdata_o = wdata_req;
        mem_stall_o  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    sel_d         = sel_q;
    bus_we_d      = bus_we_q;
    ld_sel_d      = ld_sel_q;
    uns_d         = uns_q;
    rf_we_d       = rf_we_q;
    size_d        = size_q;
    lane_d        = lane_q;
    result_d      = result_q;
    waddr_d       = waddr_q;
    wb_result_d   = wb_result_q;
    wb_waddr_d    = wb_waddr_q;
    wb_we_d       = 1'b0;
    exc_load_d    = 1'b0;
    exc_store_d   = 1'b0;
    exc_bus_d     = 1'b0;
    exc_addr_if_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACCESS;
          addr_d   = {result_i[31:2], 2'b00};
          wdata_d  = wdata_req;
          sel_d    = sel_req;
          bus_we_d = is_store;
          ld_sel_d = is_load && !is_store && mem_ex_sel_i;
          uns_d    = mem_flags_i[4];
          rf_we_d  = we_i && !is_store;
          size_d   = size;
          lane_d   = lane;
          result_d = result_i;
          waddr_d  = waddr_i;
        end else begin
          wb_result_d   = result_i;
          wb_waddr_d    = waddr_i;
          wb_we_d       = we_i && !is_store && !mis_exc && !exc_addr_if_i;
          exc_load_d    = mis_exc && !is_store;
          exc_store_d   = mis_exc && is_store;
          exc_addr_if_d = exc_addr_if_i;
        end
      end
      ACCESS: begin
        if (done) begin
          state_d    = IDLE;
          wb_waddr_d = waddr_q;
          if (dmem_err_i) begin
            wb_result_d = result_q;
            exc_bus_d   = 1'b1;
          end else begin
            wb_result_d = ld_sel_q ? load_extract(dmem_data_i, lane_q, size_q, uns_q) : result_q;
            wb_we_d     = rf_we_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      sel_q         <= 4'h0;
      bus_we_q      <= 1'b0;
      ld_sel_q      <= 1'b0;
      uns_q         <= 1'b0;
      rf_we_q       <= 1'b0;
      size_q        <= 2'b00;
      lane_q        <= 2'b00;
      result_q      <= 32'h0;
      waddr_q       <= 5'h0;
      wb_result_q   <= 32'h0;
      wb_waddr_q    <= 5'h0;
      wb_we_q       <= 1'b0;
      exc_load_q    <= 1'b0;
      exc_store_q   <= 1'b0;
      exc_bus_q     <= 1'b0;
      exc_addr_if_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      sel_q         <= sel_d;
      bus_we_q      <= bus_we_d;
      ld_sel_q      <= ld_sel_d;
      uns_q         <= uns_d;
      rf_we_q       <= rf_we_d;
      size_q        <= size_d;
      lane_q        <= lane_d;
      result_q      <= result_d;
      waddr_q       <= waddr_d;
      wb_result_q   <= wb_result_d;
      wb_waddr_q    <= wb_waddr_d;
      wb_we_q       <= wb_we_d;
      exc_load_q    <= exc_load_d;
      exc_store_q   <= exc_store_d;
      exc_bus_q     <= exc_bus_d;
      exc_addr_if_q <= exc_addr_if_d;
    end
  end

  assign wb_result_o   = wb_result_q;
  assign wb_waddr_o    = wb_waddr_q;
  assign wb_we_o       = wb_we_q;
  assign exc_load_o    = exc_load_q;
  assign exc_store_o   = exc_store_q;
  assign exc_bus_o     = exc_bus_q;
  assign exc_addr_if_o = exc_addr_if_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected bus requests and writebacks,
// a bus responder and a writeback monitor pop and compare independently.
module tb_mem_stage;

  logic        clk, rst;
  logic [31:0] result_i, store_data_i;
  logic [4:0]  waddr_i;
  logic        we_i, mem_ex_sel_i, exc_addr_if_i;
  logic [5:0]  mem_flags_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_data;
  logic [3:0]  dmem_sel_o;
  logic        dmem_we_o, dmem_cyc_o, dmem_ack, dmem_err;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_waddr_o;
  logic        wb_we_o, mem_stall_o, exc_load_o, exc_store_o, exc_bus_o, exc_addr_if_o;
  logic        issue_valid;

  int n_checks = 0;
  int miscompares = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic [4:0]  waddr;
    logic [4:0]  flags; // {we, exc_load, exc_store, exc_bus, exc_addr_if}
    int          stall;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    logic        we, err, abort;
    int          wait_n;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  localparam logic [5:0] ALU = 6'b000000, LB = 6'b000001, LBU = 6'b010001, LH = 6'b000101,
                         LHU = 6'b010101, LW = 6'b001001, LW3 = 6'b001101, SB = 6'b000010,
                         SH  = 6'b000110, SW = 6'b001010;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .result_i(result_i), .store_data_i(store_data_i), .waddr_i(waddr_i), .we_i(we_i),
    .mem_flags_i(mem_flags_i), .mem_ex_sel_i(mem_ex_sel_i), .exc_addr_if_i(exc_addr_if_i),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_sel_o(dmem_sel_o),
    .dmem_we_o(dmem_we_o), .dmem_cyc_o(dmem_cyc_o),
    .dmem_data_i(dmem_data), .dmem_ack_i(dmem_ack), .dmem_err_i(dmem_err),
    .wb_result_o(wb_result_o), .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o),
    .mem_stall_o(mem_stall_o), .exc_load_o(exc_load_o), .exc_store_o(exc_store_o),
    .exc_bus_o(exc_bus_o), .exc_addr_if_o(exc_addr_if_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] wa,
                       input logic we, input logic [5:0] fl, input logic xs, input logic eif);
    result_i = res; store_data_i = sd; waddr_i = wa; we_i = we;
    mem_flags_i = fl; mem_ex_sel_i = xs; exc_addr_if_i = eif;
  endtask

  task automatic clear_in();
    drive(32'h0, 32'h0, 5'h0, 1'b0, ALU, 1'b0, 1'b0);
  endtask

  task automatic expect_wb(input logic [31:0] res, input logic cr, input logic [4:0] wa,
                           input logic [4:0] fl, input int st);
    wb_exp_t e;
    e.res = res; e.chk_res = cr; e.waddr = wa; e.flags = fl; e.stall = st;
    wb_q.push_back(e);
  endtask

  task automatic expect_bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel,
                            input logic we, input int wn, input logic [31:0] rdata,
                            input logic err, input logic abort);
    bus_exp_t b;
    b.addr = addr; b.wdata = wdata; b.sel = sel; b.we = we; b.wait_n = wn;
    b.rdata = rdata; b.err = err; b.abort = abort;
    bus_q.push_back(b);
  endtask

  // Present the op until the stage stops stalling, then retire it on the next edge.
  task automatic run(input string nm);
    bit ok;
    ok = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_stall_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      miscompares++;
      $display("FAIL %s_timeout: stall still 1, expected release within 40 cycles", nm);
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    clear_in();
  endtask

  // Bus responder: checks each request, keeps it waiting wait_n cycles, then answers.
  initial begin
    bus_exp_t b;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_data = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      dmem_ack = 1'b0;
      dmem_err = 1'b0;
      if (dmem_cyc_o) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          miscompares++;
          $display("FAIL unexpected_cyc: got cyc=1 addr=%h, expected no bus cycle", dmem_addr_o);
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr", dmem_addr_o, b.addr);
          chk("bus_wdata", dmem_wdata_o, b.wdata);
          chk("bus_sel_we", {27'h0, dmem_sel_o, dmem_we_o}, {27'h0, b.sel, b.we});
          repeat (b.wait_n) begin
            @(posedge clk);
            #2;
            if (!b.abort) begin
              chk("hold_addr", dmem_addr_o, b.addr);
              chk("hold_wdata", dmem_wdata_o, b.wdata);
              chk("hold_cyc_sel_we", {26'h0, dmem_cyc_o, dmem_sel_o, dmem_we_o},
                  {26'h0, 1'b1, b.sel, b.we});
            end
          end
          dmem_data = b.rdata;
          dmem_ack  = 1'b1;
          dmem_err  = b.err;
        end
      end
    end
  end

  // Writeback monitor: a retire happens on every edge where an issued op is not stalled.
  initial begin
    wb_exp_t e;
    logic ret;
    forever begin
      @(posedge clk);
      ret = rst && issue_valid && !mem_stall_o;
      if (rst && issue_valid && mem_stall_o) stall_cnt++;
      #1;
      if (ret) begin
        if (wb_q.size() == 0) begin
          n_checks++;
          miscompares++;
          $display("FAIL unexpected_retire: got result %h, expected no writeback", wb_result_o);
        end else begin
          e = wb_q.pop_front();
          if (e.chk_res) chk("wb_result", wb_result_o, e.res);
          chk("wb_waddr", {27'h0, wb_waddr_o}, {27'h0, e.waddr});
          chk("wb_we_exc", {27'h0, wb_we_o, exc_load_o, exc_store_o, exc_bus_o, exc_addr_if_o},
              {27'h0, e.flags});
          chk("stall_cycles", stall_cnt, e.stall);
        end
        stall_cnt = 0;
      end else begin
        chk("bubble", {27'h0, wb_we_o, exc_load_o, exc_store_o, exc_bus_o, exc_addr_if_o}, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    issue_valid = 1'b0;
    rst = 1'b1;
    drive(32'h100, 32'h0, 5'd5, 1'b1, LW, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #2;
    chk("rst_cyc_stall", {30'h0, dmem_cyc_o, mem_stall_o}, 32'h0);
    chk("rst_sel_we", {27'h0, dmem_sel_o, dmem_we_o}, 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_wb_result", wb_result_o, 32'h0);
    chk("rst_wb_waddr_we", {26'h0, wb_waddr_o, wb_we_o}, 32'h0);
    chk("rst_exc", {28'h0, exc_load_o, exc_store_o, exc_bus_o, exc_addr_if_o}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_in();
    rst = 1'b1;
    @(posedge clk);
    #1;

    expect_bus(32'h100, 32'h0, 4'b1111, 1'b0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
    expect_wb(32'hDEADBEEF, 1'b1, 5'd5, 5'b10000, 3);
    drive(32'h100, 32'h0, 5'd5, 1'b1, LW, 1'b1, 1'b0); run("lw");

    expect_bus(32'h100, 32'h0, 4'b1000, 1'b0, 1, 32'h80112233, 1'b0, 1'b0);
    expect_wb(32'hFFFFFF80, 1'b1, 5'd6, 5'b10000, 1);
    drive(32'h103, 32'h0, 5'd6, 1'b1, LB, 1'b1, 1'b0); run("lb");

    expect_bus(32'h100, 32'h0, 4'b1000, 1'b0, 1, 32'h80112233, 1'b0, 1'b0);
    expect_wb(32'h00000080, 1'b1, 5'd6, 5'b10000, 1);
    drive(32'h103, 32'h0, 5'd6, 1'b1, LBU, 1'b1, 1'b0); run("lbu");

    expect_bus(32'h200, 32'hABCDABCD, 4'b1100, 1'b1, 2, 32'h0, 1'b0, 1'b0);
    expect_wb(32'h202, 1'b1, 5'd9, 5'b00000, 2);
    drive(32'h202, 32'h0000ABCD, 5'd9, 1'b1, SH, 1'b0, 1'b0); run("sh");

    expect_wb(32'h42, 1'b1, 5'd3, 5'b10000, 0);
    drive(32'h42, 32'h0, 5'd3, 1'b1, 6'b100000, 1'b0, 1'b0); run("alu");

`ifdef MEM_MISALIGN_EXC_EN
    expect_wb(32'h102, 1'b1, 5'd4, 5'b01000, 0);
    drive(32'h102, 32'h0, 5'd4, 1'b1, LW, 1'b1, 1'b0); run("lw_misaligned");
    expect_wb(32'h206, 1'b1, 5'd2, 5'b00100, 0);
    drive(32'h206, 32'h13579BDF, 5'd2, 1'b1, SW, 1'b0, 1'b0); run("sw_misaligned");
`else
    expect_bus(32'h100, 32'h0, 4'b1111, 1'b0, 1, 32'h0BADF00D, 1'b0, 1'b0);
    expect_wb(32'h0BADF00D, 1'b1, 5'd4, 5'b10000, 1);
    drive(32'h102, 32'h0, 5'd4, 1'b1, LW, 1'b1, 1'b0); run("lw_misaligned");
    expect_bus(32'h204, 32'h13579BDF, 4'b1111, 1'b1, 1, 32'h0, 1'b0, 1'b0);
    expect_wb(32'h206, 1'b1, 5'd2, 5'b00000, 1);
    drive(32'h206, 32'h13579BDF, 5'd2, 1'b1, SW, 1'b0, 1'b0); run("sw_misaligned");
`endif

    expect_bus(32'h400, 32'h0, 4'b1111, 1'b0, 2, 32'h12345678, 1'b1, 1'b0);
    expect_wb(32'h0, 1'b0, 5'd7, 5'b00010, 2);
    drive(32'h400, 32'h0, 5'd7, 1'b1, LW, 1'b1, 1'b0); run("lw_bus_err");

    expect_bus(32'h300, 32'h0, 4'b1100, 1'b0, 1, 32'h80017FFF, 1'b0, 1'b0);
    expect_wb(32'hFFFF8001, 1'b1, 5'd8, 5'b10000, 1);
    drive(32'h302, 32'h0, 5'd8, 1'b1, LH, 1'b1, 1'b0); run("lh");

    expect_bus(32'h300, 32'h0, 4'b0011, 1'b0, 1, 32'h8001F00D, 1'b0, 1'b0);
    expect_wb(32'h0000F00D, 1'b1, 5'd8, 5'b10000, 1);
    drive(32'h300, 32'h0, 5'd8, 1'b1, LHU, 1'b1, 1'b0); run("lhu");

    expect_bus(32'h500, 32'h78787878, 4'b0010, 1'b1, 1, 32'h0, 1'b0, 1'b0);
    expect_wb(32'h501, 1'b1, 5'd1, 5'b00000, 1);
    drive(32'h501, 32'h12345678, 5'd1, 1'b0, SB, 1'b0, 1'b0); run("sb");

    expect_bus(32'h600, 32'hCAFEF00D, 4'b1111, 1'b1, 2, 32'h0, 1'b0, 1'b0);
    expect_wb(32'h600, 1'b1, 5'd1, 5'b00000, 2);
    drive(32'h600, 32'hCAFEF00D, 5'd1, 1'b1, SW, 1'b0, 1'b0); run("sw");

    expect_bus(32'h700, 32'h0, 4'b1111, 1'b0, 1, 32'h11111111, 1'b0, 1'b0);
    expect_wb(32'h700, 1'b1, 5'd10, 5'b10000, 1);
    drive(32'h700, 32'h0, 5'd10, 1'b1, LW, 1'b0, 1'b0); run("lw_alu_sel");

    expect_wb(32'h55, 1'b1, 5'd11, 5'b00001, 0);
    drive(32'h55, 32'h0, 5'd11, 1'b1, ALU, 1'b0, 1'b1); run("alu_exc_if");

    expect_bus(32'h800, 32'h0, 4'b1111, 1'b0, 1, 32'hA5A5A5A5, 1'b0, 1'b0);
    expect_wb(32'hA5A5A5A5, 1'b1, 5'd12, 5'b10000, 1);
    drive(32'h800, 32'h0, 5'd12, 1'b1, LW3, 1'b1, 1'b0); run("lw_size11");

    // Reset in the middle of a bus wait; the responder acks late, after reset is released.
    expect_bus(32'hA00, 32'h0, 4'b1111, 1'b0, 4, 32'hBAD0BAD0, 1'b0, 1'b1);
    drive(32'hA00, 32'h0, 5'd14, 1'b1, LW, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cyc_stall", {30'h0, dmem_cyc_o, mem_stall_o}, 32'h3);
    rst = 1'b0;
    #1;
    chk("mid_rst_cyc_stall", {30'h0, dmem_cyc_o, mem_stall_o}, 32'h0);
    chk("mid_rst_sel_addr", {dmem_addr_o[27:0], dmem_sel_o}, 32'h0);
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("late_ack_cyc", {31'h0, dmem_cyc_o}, 32'h0);

    expect_bus(32'h900, 32'h0, 4'b1111, 1'b0, 1, 32'h600DCAFE, 1'b0, 1'b0);
    expect_wb(32'h600DCAFE, 1'b1, 5'd13, 5'b10000, 1);
    drive(32'h900, 32'h0, 5'd13, 1'b1, LW, 1'b1, 1'b0); run("lw_after_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("wb_q_empty", wb_q.size(), 32'h0);
    chk("bus_q_empty", bus_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, miscompares);
    $finish;
  end

endmodule
